// File: rtl/branch_pc_unit.sv
// branch_pc_unit: next-PC and branch-resolution unit for the single-cycle core.
//
// This unit owns the architectural PC. It resolves the six RV32I conditional
// branches and JAL/JALR. A taken transfer whose target has bit 1 set is
// redirected to TRAP_VEC by a two-state RUN/TRAP FSM. Two saturating counters
// track retired and taken conditional branches.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold PC, bad_addr and counters (trap_ack is still sampled)
//   branch/jal/jalr instruction class (priority jalr > jal > branch)
//   funct3          branch condition select
//   rs1_data        operand 1 and JALR base; rs2_data is operand 2
//   immgen          sign-extended immediate (halfword units for branch/JAL)
//   trap_ack        handler acknowledges the misalign trap
//   pc              registered PC
//   pc_plus4        link value (combinational)
//   taken           control transfer taken this cycle (combinational)
//   misalign        high while the FSM is in TRAP
//   bad_addr        last misaligned target
//   br_count        retired conditional branches (saturating)
//   taken_count     taken conditional branches (saturating)
module branch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     TRAP_VEC = 32'h0000_0100,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  immgen,
    input  logic             trap_ack,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             taken,
    output logic             misalign,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VEC);

    typedef enum logic {RUN, TRAP} state_t;

    state_t          state_q, state_d;
    logic            cond;
    logic            sel_br;
    logic            mis;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] tgt;

    // Branch condition
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data <  rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
    end

    // Targets wrap modulo 2^XLEN; the immediate is already sign-extended so
    // a plain add covers backward offsets too.
    assign br_tgt   = pc + (immgen << 1);
    assign jalr_sum = rs1_data + immgen;
    assign tgt      = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;

    // Counters only see a branch that is not shadowed by jal/jalr.
    assign sel_br   = branch & ~jal & ~jalr;
    assign taken    = jal | jalr | (branch & cond);
    assign mis      = taken & tgt[1];
    assign pc_plus4 = pc + XLEN'(4);
    assign misalign = (state_q == TRAP);

    // FSM next state; a fresh misalignment beats a same-cycle trap_ack, and
    // trap_ack is honoured even in a stalled cycle.
    always_comb begin
        state_d = state_q;
        if (!stall && mis)
            state_d = TRAP;
        else if (state_q == TRAP && trap_ack)
            state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // PC and bad_addr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            bad_addr <= '0;
        end else if (!stall) begin
            if (mis) begin
                pc       <= TRAP_PC;
                bad_addr <= tgt;
            end else if (taken) begin
                pc <= tgt;
            end else begin
                pc <= pc_plus4;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (!stall && sel_br) begin
            if (br_count != '1)
                br_count <= br_count + CNT_W'(1);
            if (cond && taken_count != '1)
                taken_count <= taken_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Parametrised next-PC and branch-resolution unit for the single-cycle core. It owns the architectural PC register and evaluates all six RV32I conditional branches plus JAL/JALR with signed two's-complement target arithmetic. It detects misaligned control-transfer targets and redirects to a trap vector through a two-state FSM. It also keeps saturating branch and taken-branch counters for performance bring-up.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 0, PC value after reset
- TRAP_VEC, 32'h0000_0100, redirect address on a misaligned target (truncated to XLEN)
- CNT_W, 16, width of the performance counters

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and counters this cycle
- branch  in  1  conditional branch instruction
- jal  in  1  JAL instruction
- jalr  in  1  JALR instruction
- funct3  in  3  branch condition select
- rs1_data  in  XLEN  operand 1, also the JALR base
- rs2_data  in  XLEN  operand 2
- immgen  in  XLEN  sign-extended immediate; halfword offset for branch/JAL, byte offset for JALR
- trap_ack  in  1  handler acknowledges the misalign trap
- pc  out  XLEN  current PC (registered)
- pc_plus4  out  XLEN  pc + 4, the link value (combinational)
- taken  out  1  control transfer taken this cycle (combinational)
- misalign  out  1  trap pending; high while the FSM is in TRAP
- bad_addr  out  XLEN  last misaligned target (registered)
- br_count  out  CNT_W  conditional branches retired
- taken_count  out  CNT_W  conditional branches taken

## Operation
- **Condition by funct3:**
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011 are never taken.
- **Targets:** all additions are modulo 2^XLEN with signed immediate. There is no sign-dependent add/subtract split.
  - branch/JAL: tgt = pc + (immgen << 1)
  - JALR: tgt = (rs1_data + immgen) & ~1
- **Select priority when several are high:** jalr > jal > branch. The decoder guarantees one-hot; the priority is still enforced.
- **taken** = jal | jalr | (branch & cond).
- **Misaligned:** taken & tgt[1]. A not-taken branch never misaligns.
- **Next PC priority:**
  1. stall → hold pc.
  2. Misaligned → pc ← TRAP_VEC, bad_addr ← tgt, FSM → TRAP.
  3. taken → pc ← tgt.
  4. Otherwise → pc ← pc_plus4.
- **FSM:**
  - RUN: a misaligned target (not stalled) moves to TRAP.
  - TRAP: PC sequencing continues normally so the handler executes. trap_ack returns to RUN.
  - A new misalignment in TRAP re-redirects to TRAP_VEC, overwrites bad_addr and stays in TRAP.
  - If a new misalignment and trap_ack occur in the same cycle, the misalignment wins.
  - trap_ack is sampled even when stall=1. trap_ack in RUN has no effect.
- **Counters:** only on non-stalled cycles where the selected instruction is a conditional branch.
  - br_count increments.
  - taken_count increments if the branch is taken.
  - Both saturate at 2^CNT_W−1 with no wrap.
  - A misaligned taken branch counts as taken.

## Timing
- **Reset (async, immediate):**
  - pc = RESET_PC
  - FSM = RUN, so misalign = 0
  - bad_addr = 0
  - br_count = 0, taken_count = 0
  - Deassertion is synchronised externally; the first update is at the first rising edge after rst_n goes high.
- **Combinational paths:** taken and pc_plus4 are valid in the same cycle as their inputs; there are no registered outputs on these paths.
- **Registered state:** pc, bad_addr, misalign and the counters update at the rising edge following the decision cycle. Latency is one cycle from a branch to the new pc.
- **Reset mid-trap:** returns to RUN immediately; no pending state survives.
- **Wrap-around:**
  - pc = 2^XLEN−4 sequential → 0.
  - pc + negative offset below 0 wraps modulo 2^XLEN.

## Test plan
- **Reset and sequencing:**
  - Stimulus: assert rst_n=0 mid-run, release it, then run 3 idle cycles.
  - Required: pc = 0, 4, 8, 12; counters 0; misalign 0.
- **Backward branch (BLT, signed):**
  - Stimulus: pc=0x100, rs1=−1, rs2=1, immgen=0xFFFF_FFF8.
  - Required: taken=1; next pc=0xF0; br_count=1; taken_count=1.
- **BLTU not taken:**
  - Stimulus: BLTU with the same operands as the BLT case.
  - Required: taken=0; pc_plus4 loaded; taken_count unchanged.
- **JALR misaligned, then ack:**
  - Stimulus: JALR with rs1=0x202, immgen=0. Then issue trap_ack two cycles later.
  - Required:
    - Target 0x202 has bit 1 set, so next pc=0x100, misalign=1, bad_addr=0x202.
    - After trap_ack, misalign=0.
- **Stall precedence:**
  - Stimulus: stall=1 with a taken JAL and trap_ack high in TRAP.
  - Required: pc, counters and bad_addr hold; FSM returns to RUN.
- **Saturation:**
  - Stimulus: CNT_W=2, then 5 taken BEQs.
  - Required: br_count and taken_count stick at 3.
